cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the cpu instruction-fetch port and its load/store port.
- Accepts one transaction at a time through a req/ack handshake and arbitrates round-robin when both ports request.
- Sequences the memory enable, write enable and read-latency wait, then returns read data to the owning port.
- Sits between the cpu core and the memory model, at the cpu top level.

Parameters:
- AW, 8, address width in bits.
- DW, 8, data width in bits.
- LAT, 1, memory read latency in cycles (legal range 1..15). m_rdata is valid LAT cycles after the cycle in which m_en is high.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_ack is seen.
- i_addr  in  AW  fetch address; stable while i_req is high.
- i_ack  out  1  one-cycle pulse; i_rdata is valid in this cycle.
- i_rdata  out  DW  fetched word.
- d_req  in  1  data request; held high until d_ack is seen.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DW  load data.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: state = IDLE. All outputs are 0. The round-robin pointer is set so that the data port wins the first tie. A reset in any state aborts the access: no ack is issued and m_en is 0 in the next cycle.
- IDLE: requests are sampled at the clock edge.
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port not served last is granted.
  - On a grant, the owner, address, we and wdata are latched and the next state is ACCESS.
  - A fetch is always a read (we = 0).
- ACCESS (1 cycle): m_en = 1, m_we = latched we, m_addr and m_wdata driven from the latches. Next state is WAIT.
- WAIT (exactly LAT cycles): a counter counts down. At the end of the last WAIT cycle, m_rdata is captured into the owner's rdata register. This applies to reads only; for writes, d_rdata is unchanged. Next state is ACK.
- ACK (1 cycle): the owner's ack is 1 and the round-robin pointer is updated to this owner. Next state is IDLE.
- m_en and m_we are 0 in every state except ACCESS. m_addr and m_wdata hold their last values.
- i_ack and d_ack are never high in the same cycle.
- Each rdata output holds its value until the next read by that port.
- Latency: a request sampled in cycle 0 gives m_en in cycle 1, capture at the end of cycle 1+LAT, and ack in cycle 2+LAT. The next sample happens in cycle 3+LAT, so back-to-back throughput is one transaction per LAT+3 cycles.
- Handshake rules:
  - The requester drops req in the cycle after ack.
  - Because IDLE follows ACK, a req still high in that IDLE cycle is treated as a new request.
  - req must not be dropped before ack; if it is, behaviour is undefined.
- All outputs are registered; there is no combinational path from req to m_en or ack.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum arb_state_t {IDLE, ACCESS, WAIT, ACK};
  - the owner constants OWNER_I = 0 and OWNER_D = 1;
  - the latency counter width constant LAT_W = 4.
- One sub-module, rr_arb2: a 2-input round-robin picker with a registered last-owner pointer and an update strobe.
- The FSM, latches and counter stay in cpu_mem_arbiter.

Test Plan:
- Reset priority: both req high while reset is held high for 2 cycles → all outputs 0 and no m_en. After release: m_en in the 2nd cycle, owner is data, d_ack comes first.
- Single fetch, LAT=1, i_addr=0x10, mem[0x10]=0xA5 → m_en=1, m_we=0, m_addr=0x10 in cycle 1; i_ack single pulse in cycle 3 with i_rdata=0xA5.
- Store then fetch: d_we=1, d_addr=0x20, d_wdata=0x3C → one cycle of m_en=m_we=1 with m_addr=0x20, m_wdata=0x3C; d_ack in cycle 3; d_rdata unchanged. A following fetch of 0x20 returns i_rdata=0x3C.
- Contention: i_req and d_req both held high for 16 cycles with LAT=1 → acks alternate D, I, D, I at 4-cycle spacing; never both acks high.
- Reset mid-operation: reset asserted in a WAIT cycle → next cycle m_en=0, busy=0, no ack. After release, the still-held req is re-granted and completes normally.
- LAT=3 build: fetch sampled in cycle 0 → m_en for exactly cycle 1, capture at the end of cycle 4, i_ack in cycle 5; busy high in cycles 1–5.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu memory arbiter: FSM states, port owner
// encodings, the latency counter width and the two-way round-robin pick.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      ACK
   } arb_state_t;

   // Owner encodings: 0 is the instruction-fetch port, 1 is the load/store port
   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   // Width of the read-latency down-counter (latency 1..15)
   localparam int LAT_W = 4;

   // Pick a port from two requests. A lone requester always wins; on a tie
   // the port that was not served last wins.
   function automatic logic rr_pick(input logic req_i,
                                    input logic req_d,
                                    input logic last_owner);
      logic pick;
      if (req_i && req_d) begin
         pick = ~last_owner;
      end else if (req_d) begin
         pick = OWNER_D;
      end else begin
         pick = OWNER_I;
      end
      return pick;
   endfunction

endpackage

// File: rtl/cpu_mem_arbiter_rr_arb2.sv
// Two-input round-robin picker. Holds the owner that was served most
// recently and offers the other port first whenever both ports request.
module rr_arb2
   import cpu_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_i,
   input  logic req_d,
   input  logic update,
   input  logic upd_owner,
   output logic grant_valid,
   output logic grant_owner
);

   logic last_owner;

   // Remember who was served last; reset to the fetch port so data wins the first tie
   always_ff @(posedge clk) begin
      if (reset) begin
         last_owner <= OWNER_I;
      end else if (update) begin
         last_owner <= upd_owner;
      end
   end

   // Combinational pick from the live requests and the stored pointer
   always_comb begin
      grant_valid = req_i | req_d;
      grant_owner = rr_pick(req_i, req_d, last_owner);
   end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between the cpu fetch
// port and the load/store port. One transaction runs at a time through
// IDLE -> ACCESS -> WAIT (LAT cycles) -> ACK, and every output is a register.
module cpu_mem_arbiter
   import cpu_pkg::*;
#(
   parameter int AW  = 8,
   parameter int DW  = 8,
   parameter int LAT = 1
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_ack,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic          busy
);

   // Counter start value: the last WAIT cycle is the one where the count reaches zero
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LAT - 1);

   arb_state_t       state;
   logic             owner;
   logic             lat_we;
   logic [LAT_W-1:0] cnt;
   logic             grant_valid;
   logic             grant_owner;
   logic             rr_update;

   // The pointer moves to the current owner during its ACK cycle, so the
   // following IDLE cycle already sees the updated priority.
   assign rr_update = (state == ACK);

   rr_arb2 u_rr (
      .clk         (clk),
      .reset       (reset),
      .req_i       (i_req),
      .req_d       (d_req),
      .update      (rr_update),
      .upd_owner   (owner),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   // Transaction sequencer: grant, strobe the memory, wait out the read latency, acknowledge
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         owner   <= OWNER_I;
         lat_we  <= 1'b0;
         cnt     <= '0;
         m_en    <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         i_ack   <= 1'b0;
         d_ack   <= 1'b0;
         i_rdata <= '0;
         d_rdata <= '0;
         busy    <= 1'b0;
      end else begin
         m_en  <= 1'b0;
         m_we  <= 1'b0;
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_valid) begin
                  owner <= grant_owner;
                  state <= ACCESS;
                  busy  <= 1'b1;
                  m_en  <= 1'b1;
                  if (grant_owner == OWNER_D) begin
                     lat_we  <= d_we;
                     m_we    <= d_we;
                     m_addr  <= d_addr;
                     m_wdata <= d_wdata;
                  end else begin
                     lat_we <= 1'b0;
                     m_we   <= 1'b0;
                     m_addr <= i_addr;
                  end
               end
            end
            ACCESS: begin
               state <= WAIT;
               cnt   <= LAT_LOAD;
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= ACK;
                  if (owner == OWNER_D) begin
                     d_ack <= 1'b1;
                     if (!lat_we) begin
                        d_rdata <= m_rdata;
                     end
                  end else begin
                     i_ack <= 1'b1;
                     if (!lat_we) begin
                        i_rdata <= m_rdata;
                     end
                  end
               end else begin
                  cnt <= cnt - LAT_W'(1);
               end
            end
            ACK: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: a LAT=1 instance exercised through
// directed steps with a scoreboard of expected acks, plus a LAT=3 instance
// checked cycle by cycle for a single fetch.
module tb_cpu_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic preload;

   logic       i_req, d_req, d_we;
   logic [7:0] i_addr, d_addr, d_wdata;
   logic       i_ack, d_ack, m_en, m_we, busy;
   logic [7:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

   logic       b_i_req;
   logic [7:0] b_i_addr;
   logic       b_i_ack, b_d_ack, b_m_en, b_m_we, b_busy;
   logic [7:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;

   typedef struct {
      logic       port;
      logic [7:0] rdata;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] shadow [256];
   logic [7:0] i_model;
   logic [7:0] d_model;
   int         checks = 0;
   int         errors = 0;

   cpu_mem_arbiter #(.AW(8), .DW(8), .LAT(1)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .busy(busy)
   );

   cpu_mem_arbiter #(.AW(8), .DW(8), .LAT(3)) dut_lat3 (
      .clk(clk), .reset(reset),
      .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
      .d_req(1'b0), .d_we(1'b0), .d_addr(8'h00), .d_wdata(8'h00),
      .d_ack(b_d_ack), .d_rdata(b_d_rdata),
      .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
      .m_rdata(b_m_rdata), .busy(b_busy)
   );

   // Memory model for the LAT=1 instance; idle cycles return a marker value
   logic [7:0] mem_a [256];
   logic [7:0] pipe_a;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem_a[i] = 8'(i) ^ 8'hB5;
      end else if (m_en && m_we) begin
         mem_a[m_addr] = m_wdata;
      end
      pipe_a <= (m_en && !m_we) ? mem_a[m_addr] : 8'hEE;
   end
   assign m_rdata = pipe_a;

   // Memory model for the LAT=3 instance: three-stage read pipeline
   logic [7:0] mem_b [256];
   logic [7:0] pipe_b [3];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem_b[i] = 8'(i) ^ 8'hB5;
      end else if (b_m_en && b_m_we) begin
         mem_b[b_m_addr] = b_m_wdata;
      end
      pipe_b[0] <= (b_m_en && !b_m_we) ? mem_b[b_m_addr] : 8'hEE;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign b_m_rdata = pipe_b[2];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise a request and push the ack it should eventually produce
   task automatic applyStimulus(input logic port, input logic we,
                                input logic [7:0] addr, input logic [7:0] wdata);
      exp_t e;
      if (port) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
         if (we) shadow[addr] = wdata;
         else    d_model = shadow[addr];
         e.rdata = d_model;
      end else begin
         i_req = 1'b1; i_addr = addr;
         i_model = shadow[addr];
         e.rdata = i_model;
      end
      e.port = port;
      exp_q.push_back(e);
   endtask

   // Wait (bounded) for the port's ack, then drop its request next cycle; n = -1 on timeout
   task automatic waitAck(input logic port, input int max, output int n);
      n = 0;
      for (int k = 0; k < max; k++) begin
         @(negedge clk);
         n++;
         if ((port ? d_ack : i_ack) === 1'b1) begin
            tick();
            if (port) d_req = 1'b0; else i_req = 1'b0;
            return;
         end
         tick();
      end
      n = -1;
      if (port) d_req = 1'b0; else i_req = 1'b0;
   endtask

   // Scoreboard: every ack must match the oldest outstanding expectation
   always @(negedge clk) begin : monitor
      exp_t e;
      if (i_ack === 1'b1 || d_ack === 1'b1) begin
         checkOutput("ack_exclusive", {31'd0, i_ack & d_ack}, 32'd0);
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("[TB] FAIL ack_unexpected observed=%0d expected=1", exp_q.size());
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("ack_port", {31'd0, d_ack}, {31'd0, e.port});
            checkOutput("ack_rdata", {24'd0, (e.port ? d_rdata : i_rdata)}, {24'd0, e.rdata});
         end
      end
   end

   initial begin
      #20000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int nacks;
      int ack_cyc [4];
      logic ack_port [4];

      reset = 1'b1; preload = 1'b1;
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      i_addr = 8'h41; d_addr = 8'h40; d_wdata = 8'h00;
      b_i_req = 1'b0; b_i_addr = 8'h00;
      i_model = 8'h00; d_model = 8'h00;
      for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'hB5;
      tick();

      // Reset held with both requests high
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput("rst_m_en", {31'd0, m_en}, 32'd0);
         checkOutput("rst_busy", {31'd0, busy}, 32'd0);
         checkOutput("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
         checkOutput("rst_m_bus", {15'd0, m_we, m_addr, m_wdata}, 32'd0);
         checkOutput("rst_rdata", {16'd0, i_rdata, d_rdata}, 32'd0);
         checkOutput("rst_lat3", {28'd0, b_m_en, b_busy, b_i_ack, b_d_ack}, 32'd0);
         tick();
      end
      reset = 1'b0; preload = 1'b0;
      applyStimulus(1'b1, 1'b0, 8'h40, 8'h00);
      applyStimulus(1'b0, 1'b0, 8'h41, 8'h00);
      @(negedge clk);
      checkOutput("t1_c0_m_en", {31'd0, m_en}, 32'd0);
      tick();
      @(negedge clk);
      checkOutput("t1_c1_m_en", {31'd0, m_en}, 32'd1);
      checkOutput("t1_c1_m_addr", {24'd0, m_addr}, 32'h40);
      tick();
      waitAck(1'b1, 10, n);
      checkOutput("t1_d_ack_cycle", n, 2);
      waitAck(1'b0, 10, n);
      checkOutput("t1_i_ack_cycle", n, 4);

      // Single fetch of 0x10
      tick();
      applyStimulus(1'b0, 1'b0, 8'h10, 8'h00);
      @(negedge clk);
      checkOutput("t2_c0_busy", {31'd0, busy}, 32'd0);
      tick();
      @(negedge clk);
      checkOutput("t2_c1_m_en_we", {30'd0, m_en, m_we}, 32'h2);
      checkOutput("t2_c1_m_addr", {24'd0, m_addr}, 32'h10);
      checkOutput("t2_c1_busy", {31'd0, busy}, 32'd1);
      tick();
      @(negedge clk);
      checkOutput("t2_c2_m_en", {31'd0, m_en}, 32'd0);
      tick();
      waitAck(1'b0, 10, n);
      checkOutput("t2_i_ack_cycle", n, 1);
      @(negedge clk);
      checkOutput("t2_ack_pulse", {31'd0, i_ack}, 32'd0);
      checkOutput("t2_i_rdata_hold", {24'd0, i_rdata}, 32'hA5);

      // Store 0x3C to 0x20, then fetch it back
      tick();
      applyStimulus(1'b1, 1'b1, 8'h20, 8'h3C);
      @(negedge clk);
      checkOutput("t3_c0_m_en", {31'd0, m_en}, 32'd0);
      tick();
      @(negedge clk);
      checkOutput("t3_c1_m_en_we", {30'd0, m_en, m_we}, 32'h3);
      checkOutput("t3_c1_m_addr", {24'd0, m_addr}, 32'h20);
      checkOutput("t3_c1_m_wdata", {24'd0, m_wdata}, 32'h3C);
      tick();
      @(negedge clk);
      checkOutput("t3_c2_m_en_we", {30'd0, m_en, m_we}, 32'h0);
      checkOutput("t3_c2_m_wdata", {24'd0, m_wdata}, 32'h3C);
      tick();
      waitAck(1'b1, 10, n);
      checkOutput("t3_d_ack_cycle", n, 1);
      d_we = 1'b0;
      @(negedge clk);
      checkOutput("t3_d_rdata_kept", {24'd0, d_rdata}, {24'd0, d_model});
      tick();
      applyStimulus(1'b0, 1'b0, 8'h20, 8'h00);
      waitAck(1'b0, 10, n);
      checkOutput("t3_fetch_ack_cycle", n, 4);

      // Contention: both ports held for 16 cycles
      applyStimulus(1'b1, 1'b0, 8'h31, 8'h00);
      applyStimulus(1'b0, 1'b0, 8'h30, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h31, 8'h00);
      applyStimulus(1'b0, 1'b0, 8'h30, 8'h00);
      nacks = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         checkOutput("t4_ack_excl", {31'd0, i_ack & d_ack}, 32'd0);
         if ((i_ack === 1'b1 || d_ack === 1'b1) && nacks < 4) begin
            ack_cyc[nacks] = k;
            ack_port[nacks] = d_ack;
            nacks++;
         end
         tick();
      end
      i_req = 1'b0; d_req = 1'b0;
      checkOutput("t4_ack_count", nacks, 4);
      for (int j = 0; j < nacks; j++) begin
         checkOutput("t4_ack_cycle", ack_cyc[j], 3 + 4 * j);
         checkOutput("t4_ack_port", {31'd0, ack_port[j]}, {31'd0, ((j % 2) == 0)});
      end

      // Reset during WAIT, then the held request is re-granted
      tick();
      applyStimulus(1'b1, 1'b0, 8'h50, 8'h00);
      tick();
      tick();
      reset = 1'b1;
      @(negedge clk);
      checkOutput("t5_wait_busy", {31'd0, busy}, 32'd1);
      tick();
      reset = 1'b0;
      exp_q.delete();
      i_model = 8'h00; d_model = 8'h00;
      applyStimulus(1'b1, 1'b0, 8'h50, 8'h00);
      @(negedge clk);
      checkOutput("t5_abort_m_en", {31'd0, m_en}, 32'd0);
      checkOutput("t5_abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("t5_abort_acks", {30'd0, i_ack, d_ack}, 32'd0);
      checkOutput("t5_abort_d_rdata", {24'd0, d_rdata}, 32'd0);
      tick();
      waitAck(1'b1, 10, n);
      checkOutput("t5_regrant_ack_cycle", n, 3);

      // LAT=3 instance: single fetch of 0x77
      tick();
      b_i_addr = 8'h77; b_i_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checkOutput("t6_m_en", {31'd0, b_m_en}, {31'd0, (k == 1)});
         checkOutput("t6_busy", {31'd0, b_busy}, {31'd0, (k >= 1 && k <= 5)});
         checkOutput("t6_i_ack", {31'd0, b_i_ack}, {31'd0, (k == 5)});
         checkOutput("t6_d_ack", {31'd0, b_d_ack}, 32'd0);
         if (k == 1) checkOutput("t6_m_addr", {24'd0, b_m_addr}, 32'h77);
         if (k == 4) checkOutput("t6_rdata_early", {24'd0, b_i_rdata}, 32'h00);
         if (k == 5) checkOutput("t6_rdata", {24'd0, b_i_rdata}, {24'd0, shadow[8'h77]});
         tick();
         if (k == 5) b_i_req = 1'b0;
      end

      checkOutput("final_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
